// File: rtl/mem_access.sv
// Memory-access stage: single-request handshake to the memory controller, load extension, write-back mux.
// Optional `MEM_FWD_EN adds fwd_w_* outputs that forward the write-back triple to ID, suppressing in-flight loads.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_w_addr,
    input  logic        ex_w_req,
    input  logic [31:0] ex_w_data,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_wdata,
    input  logic [5:0]  stall_state,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata,
    output logic        mc_req,
    output logic        mc_we,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    output logic [1:0]  mc_len,
    output logic        stall_req,
    output logic [4:0]  mem_w_addr,
    output logic        mem_w_req,
    output logic [31:0] mem_w_data
`ifdef MEM_FWD_EN
   ,output logic        fwd_w_req,
    output logic [4:0]  fwd_w_addr,
    output logic [31:0] fwd_w_data
`endif
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_mc_req;
    logic        r_mc_we;
    logic [31:0] r_mc_addr;
    logic [31:0] r_mc_wdata;
    logic [1:0]  r_mc_len;
    logic [31:0] r_result;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [1:0]  w_len;
    logic [31:0] w_ld_ext;
    logic        w_stall_req;
    logic [31:0] w_mem_w_data;

    // Only bit 3 (mem_wb capture) matters to this stage.
    logic        w_unused_stall;
    assign w_unused_stall = ^{stall_state[5:4], stall_state[2:0]};

    assign w_is_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LHU);
    assign w_is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
    assign w_is_mem   = w_is_load || w_is_store;

    always_comb begin
        w_len = 2'd0;
        case (ex_mem_op)
            OP_LH, OP_LHU, OP_SH: w_len = 2'd1;
            OP_LW, OP_SW:         w_len = 2'd3;
            default:              w_len = 2'd0;
        endcase
    end

    always_comb begin
        w_ld_ext = mc_rdata;
        case (ex_mem_op)
            OP_LB:   w_ld_ext = {{24{mc_rdata[7]}}, mc_rdata[7:0]};
            OP_LBU:  w_ld_ext = {24'd0, mc_rdata[7:0]};
            OP_LH:   w_ld_ext = {{16{mc_rdata[15]}}, mc_rdata[15:0]};
            OP_LHU:  w_ld_ext = {16'd0, mc_rdata[15:0]};
            default: w_ld_ext = mc_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mc_req   <= 1'b0;
            r_mc_we    <= 1'b0;
            r_mc_addr  <= 32'd0;
            r_mc_wdata <= 32'd0;
            r_mc_len   <= 2'd0;
            r_result   <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        r_mc_req   <= 1'b1;
                        r_mc_we    <= w_is_store;
                        r_mc_addr  <= ex_mem_addr;
                        r_mc_wdata <= ex_mem_wdata;
                        r_mc_len   <= w_len;
                    end
                end
                S_WAIT: begin
                    // ex_mem is frozen while stalled, so the op still selects the extension here.
                    if (mc_done) begin
                        r_mc_req <= 1'b0;
                        r_result <= w_ld_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        w_stall_req  = 1'b0;
        w_mem_w_data = ex_w_data;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    w_stall_req = 1'b1;
                    w_next      = S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall_req = 1'b1;
                if (mc_done) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_is_load) begin
                    w_mem_w_data = r_result;
                end
                if (!stall_state[3]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign mc_req     = r_mc_req;
    assign mc_we      = r_mc_we;
    assign mc_addr    = r_mc_addr;
    assign mc_wdata   = r_mc_wdata;
    assign mc_len     = r_mc_len;
    assign stall_req  = w_stall_req;
    assign mem_w_addr = ex_w_addr;
    assign mem_w_req  = ex_w_req;
    assign mem_w_data = w_mem_w_data;

`ifdef MEM_FWD_EN
    // A load's value is not known until DONE, so never advertise it earlier.
    assign fwd_w_req  = ex_w_req && !(w_is_load && ((r_state == S_IDLE) || (r_state == S_WAIT)));
    assign fwd_w_addr = ex_w_addr;
    assign fwd_w_data = w_mem_w_data;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, loads, stores, back-to-back, reset mid-access, DONE hold.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [4:0]  ex_w_addr;
    logic        ex_w_req;
    logic [31:0] ex_w_data;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_wdata;
    logic [5:0]  stall_state;
    logic        mc_done;
    logic [31:0] mc_rdata;
    logic        mc_req;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic [1:0]  mc_len;
    logic        stall_req;
    logic [4:0]  mem_w_addr;
    logic        mem_w_req;
    logic [31:0] mem_w_data;
`ifdef MEM_FWD_EN
    logic        fwd_w_req;
    logic [4:0]  fwd_w_addr;
    logic [31:0] fwd_w_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .ex_w_addr    (ex_w_addr),
        .ex_w_req     (ex_w_req),
        .ex_w_data    (ex_w_data),
        .ex_mem_op    (ex_mem_op),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_wdata (ex_mem_wdata),
        .stall_state  (stall_state),
        .mc_done      (mc_done),
        .mc_rdata     (mc_rdata),
        .mc_req       (mc_req),
        .mc_we        (mc_we),
        .mc_addr      (mc_addr),
        .mc_wdata     (mc_wdata),
        .mc_len       (mc_len),
        .stall_req    (stall_req),
        .mem_w_addr   (mem_w_addr),
        .mem_w_req    (mem_w_req),
        .mem_w_data   (mem_w_data)
`ifdef MEM_FWD_EN
       ,.fwd_w_req    (fwd_w_req),
        .fwd_w_addr   (fwd_w_addr),
        .fwd_w_data   (fwd_w_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ex_mem_op = 4'd0; ex_w_addr = 5'd0; ex_w_req = 1'b0; ex_w_data = 32'd0;
        ex_mem_addr = 32'd0; ex_mem_wdata = 32'd0; stall_state = 6'd0; mc_done = 1'b0; mc_rdata = 32'd0;
        tick; tick;
        @(negedge clk);
        n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("FAIL reset_mc_req got=%b exp=0", mc_req); end
        n_cmp++; if (mc_we !== 1'b0) begin n_err++; $display("FAIL reset_mc_we got=%b exp=0", mc_we); end
        n_cmp++; if (mc_addr !== 32'd0) begin n_err++; $display("FAIL reset_mc_addr got=%h exp=0", mc_addr); end
        n_cmp++; if (mc_wdata !== 32'd0) begin n_err++; $display("FAIL reset_mc_wdata got=%h exp=0", mc_wdata); end
        n_cmp++; if (mc_len !== 2'd0) begin n_err++; $display("FAIL reset_mc_len got=%0d exp=0", mc_len); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        tick; rst = 1'b0;
    endtask

    task automatic test_alu(input logic [3:0] op);
        tick;
        ex_mem_op = op; ex_w_addr = 5'd5; ex_w_req = 1'b1; ex_w_data = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (mem_w_addr !== 5'd5) begin n_err++; $display("FAIL alu_addr op=%0d got=%0d exp=5", op, mem_w_addr); end
            n_cmp++; if (mem_w_req !== 1'b1) begin n_err++; $display("FAIL alu_req op=%0d got=%b exp=1", op, mem_w_req); end
            n_cmp++; if (mem_w_data !== 32'h1234) begin n_err++; $display("FAIL alu_data op=%0d got=%h exp=1234", op, mem_w_data); end
            n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL alu_stall op=%0d got=%b exp=0", op, stall_req); end
            n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("FAIL alu_mc_req op=%0d got=%b exp=0", op, mc_req); end
            tick;
        end
    endtask

    // Load presented in cycle 0, mc_done in cycle k, DONE in cycle k+1, back to IDLE after.
    task automatic test_load(input logic [3:0] op, input logic [31:0] rdata,
                             input logic [31:0] exp_data, input logic [1:0] exp_len, input int k);
        tick;
        ex_mem_op = op; ex_mem_addr = 32'h100; ex_mem_wdata = 32'h0; stall_state = 6'd0;
        ex_w_addr = 5'd7; ex_w_req = 1'b1; ex_w_data = 32'h55;
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL ld_stall_c0 op=%0d got=%b exp=1", op, stall_req); end
        n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("FAIL ld_req_c0 op=%0d got=%b exp=0", op, mc_req); end
        for (int c = 1; c <= k; c++) begin
            tick;
            if (c == k) begin mc_done = 1'b1; mc_rdata = rdata; end
            @(negedge clk);
            n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL ld_stall op=%0d c=%0d got=%b exp=1", op, c, stall_req); end
            n_cmp++; if (mc_req !== 1'b1) begin n_err++; $display("FAIL ld_req op=%0d c=%0d got=%b exp=1", op, c, mc_req); end
            n_cmp++; if (mc_len !== exp_len) begin n_err++; $display("FAIL ld_len op=%0d got=%0d exp=%0d", op, mc_len, exp_len); end
            n_cmp++; if (mc_we !== 1'b0) begin n_err++; $display("FAIL ld_we op=%0d got=%b exp=0", op, mc_we); end
            n_cmp++; if (mc_addr !== 32'h100) begin n_err++; $display("FAIL ld_addr op=%0d got=%h exp=100", op, mc_addr); end
`ifdef MEM_FWD_EN
            n_cmp++; if (fwd_w_req !== 1'b0) begin n_err++; $display("FAIL ld_fwd_req op=%0d got=%b exp=0", op, fwd_w_req); end
`endif
        end
        tick;
        mc_done = 1'b0; mc_rdata = 32'h9999_9999;
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL ld_done_stall op=%0d got=%b exp=0", op, stall_req); end
        n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("FAIL ld_done_req op=%0d got=%b exp=0", op, mc_req); end
        n_cmp++; if (mem_w_data !== exp_data) begin n_err++; $display("FAIL ld_data op=%0d got=%h exp=%h", op, mem_w_data, exp_data); end
        n_cmp++; if (mem_w_addr !== 5'd7) begin n_err++; $display("FAIL ld_waddr op=%0d got=%0d exp=7", op, mem_w_addr); end
        tick;
        ex_mem_op = 4'd0;
        @(negedge clk);
        n_cmp++; if (mem_w_data !== 32'h55) begin n_err++; $display("FAIL ld_idle_data op=%0d got=%h exp=55", op, mem_w_data); end
    endtask

    task automatic test_store;
        tick;
        ex_mem_op = 4'd8; ex_mem_addr = 32'h200; ex_mem_wdata = 32'hDEADBEEF;
        ex_w_addr = 5'd0; ex_w_req = 1'b0; ex_w_data = 32'h200;
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (c == 4) begin mc_done = 1'b1; mc_rdata = 32'h0BAD_0BAD; end
            @(negedge clk);
            n_cmp++; if (mc_we !== 1'b1) begin n_err++; $display("FAIL st_we c=%0d got=%b exp=1", c, mc_we); end
            n_cmp++; if (mc_len !== 2'd3) begin n_err++; $display("FAIL st_len c=%0d got=%0d exp=3", c, mc_len); end
            n_cmp++; if (mc_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL st_wdata c=%0d got=%h exp=deadbeef", c, mc_wdata); end
            n_cmp++; if (mc_addr !== 32'h200) begin n_err++; $display("FAIL st_addr c=%0d got=%h exp=200", c, mc_addr); end
            n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL st_stall c=%0d got=%b exp=1", c, stall_req); end
        end
        tick;
        mc_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_w_req !== 1'b0) begin n_err++; $display("FAIL st_wreq got=%b exp=0", mem_w_req); end
        n_cmp++; if (mem_w_data !== 32'h200) begin n_err++; $display("FAIL st_wdata_wb got=%h exp=200", mem_w_data); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL st_done_stall got=%b exp=0", stall_req); end
        tick;
        ex_mem_op = 4'd0;
    endtask

    task automatic test_back_to_back;
        tick;
        ex_mem_op = 4'd2; ex_mem_addr = 32'h300; ex_w_addr = 5'd9; ex_w_req = 1'b1; ex_w_data = 32'h55;
        tick;
        mc_done = 1'b1; mc_rdata = 32'h0000_8001;
        @(negedge clk);
        n_cmp++; if (mc_len !== 2'd1) begin n_err++; $display("FAIL b2b_lh_len got=%0d exp=1", mc_len); end
        tick;
        mc_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_w_data !== 32'hFFFF8001) begin n_err++; $display("FAIL b2b_lh_data got=%h exp=ffff8001", mem_w_data); end
        n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("FAIL b2b_req_done got=%b exp=0", mc_req); end
        tick;
        ex_mem_op = 4'd6; ex_mem_addr = 32'h301; ex_mem_wdata = 32'h0000_00A5; ex_w_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL b2b_sb_stall got=%b exp=1", stall_req); end
        n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("FAIL b2b_req_gap got=%b exp=0", mc_req); end
        tick;
        @(negedge clk);
        n_cmp++; if (mc_req !== 1'b1) begin n_err++; $display("FAIL b2b_sb_req got=%b exp=1", mc_req); end
        n_cmp++; if (mc_we !== 1'b1 || mc_len !== 2'd0 || mc_addr !== 32'h301) begin
            n_err++; $display("FAIL b2b_sb_cmd we=%b len=%0d addr=%h exp=1/0/301", mc_we, mc_len, mc_addr);
        end
        tick;
        mc_done = 1'b1;
        tick;
        mc_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (mc_req !== 1'b0 || stall_req !== 1'b0) begin
            n_err++; $display("FAIL b2b_sb_done req=%b stall=%b exp=0/0", mc_req, stall_req);
        end
        tick;
        ex_mem_op = 4'd0;
        @(negedge clk);
        n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("FAIL b2b_no_dup got=%b exp=0", mc_req); end
    endtask

    task automatic test_reset_mid;
        tick;
        ex_mem_op = 4'd3; ex_mem_addr = 32'h400; ex_w_addr = 5'd3; ex_w_req = 1'b1; ex_w_data = 32'h77;
        tick;
        @(negedge clk);
        n_cmp++; if (mc_req !== 1'b1) begin n_err++; $display("FAIL rstm_req_wait got=%b exp=1", mc_req); end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; ex_mem_op = 4'd0;
        @(negedge clk);
        n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("FAIL rstm_req got=%b exp=0", mc_req); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL rstm_stall got=%b exp=0", stall_req); end
        n_cmp++; if (mc_addr !== 32'd0) begin n_err++; $display("FAIL rstm_addr got=%h exp=0", mc_addr); end
        tick;
        mc_done = 1'b1; mc_rdata = 32'hFFFF_FFFF;
        tick;
        mc_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (mc_req !== 1'b0 || stall_req !== 1'b0) begin
            n_err++; $display("FAIL rstm_late_done req=%b stall=%b exp=0/0", mc_req, stall_req);
        end
        n_cmp++; if (mem_w_data !== 32'h77) begin n_err++; $display("FAIL rstm_wdata got=%h exp=77", mem_w_data); end
    endtask

    task automatic test_done_hold;
        tick;
        ex_mem_op = 4'd3; ex_mem_addr = 32'h500; ex_w_addr = 5'd11; ex_w_req = 1'b1; ex_w_data = 32'h55;
        tick;
        mc_done = 1'b1; mc_rdata = 32'hCAFEF00D;
        tick;
        mc_done = 1'b0; stall_state = 6'h08;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) stall_state = 6'd0;
            @(negedge clk);
            n_cmp++; if (mem_w_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL hold_data c=%0d got=%h exp=cafef00d", c, mem_w_data); end
            n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL hold_stall c=%0d got=%b exp=0", c, stall_req); end
            tick;
        end
        ex_mem_op = 4'd0;
        @(negedge clk);
        n_cmp++; if (mem_w_data !== 32'h55) begin n_err++; $display("FAIL hold_idle got=%h exp=55", mem_w_data); end
    endtask

    initial begin
        test_reset;
        test_alu(4'd0);
        test_alu(4'd9);
        test_load(4'd1, 32'h0000_00F0, 32'hFFFF_FFF0, 2'd0, 4);
        test_load(4'd4, 32'h0000_00F0, 32'h0000_00F0, 2'd0, 4);
        test_load(4'd2, 32'h1234_8765, 32'hFFFF_8765, 2'd1, 1);
        test_load(4'd5, 32'h1234_8765, 32'h0000_8765, 2'd1, 2);
        test_load(4'd3, 32'h8765_4321, 32'h8765_4321, 2'd3, 3);
        test_store;
        test_back_to_back;
        test_reset_mid;
        test_done_hold;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
